// File: rtl/golomb_result_streamer.sv
// golomb_result_streamer: snapshots the Golomb search results on the rising
// edge of done and streams them to the host FIFO as a framed byte sequence
// (0xA5 header, count, two bytes per 9-bit mark, optional XOR checksum).
// Optional feature macro: GOLOMB_STREAM_CHECKSUM_EN adds the trailing checksum byte.
//
// Handshake: a byte transfers on a rising clock edge where tx_valid && tx_ready.
// While tx_valid=1 and tx_ready=0, tx_data is held and tx_valid does not drop.
// tx_valid is raised without looking at tx_ready.
module golomb_result_streamer #(
    parameter int NUMPOSITIONS = 5,
    parameter int NUMRESULTS   = 10
) (
    input  logic                                       clock,
    input  logic                                       RESET,
    input  logic                                       done,
    input  logic [5:0]                                 numResults,
    input  logic [(NUMPOSITIONS+1)*9*NUMRESULTS-1:0]   results,
    output logic [7:0]                                 tx_data,
    output logic                                       tx_valid,
    input  logic                                       tx_ready,
    output logic                                       busy,
    output logic                                       frame_done,
    output logic [2:0]                                 fsm_state
);

    localparam int W  = (NUMPOSITIONS + 1) * 9 * NUMRESULTS;
    localparam int RW = (NUMRESULTS > 1) ? $clog2(NUMRESULTS) : 1;
    localparam int MW = (NUMPOSITIONS > 0) ? $clog2(NUMPOSITIONS + 1) : 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HEADER  = 3'd1;
    localparam logic [2:0] COUNT   = 3'd2;
    localparam logic [2:0] MARK_HI = 3'd3;
    localparam logic [2:0] MARK_LO = 3'd4;
`ifdef GOLOMB_STREAM_CHECKSUM_EN
    localparam logic [2:0] CHK     = 3'd5;
`endif
    localparam logic [2:0] FIN     = 3'd6;

    localparam logic [MW-1:0] LAST_MARK = MW'(NUMPOSITIONS);

    logic [2:0]    state;
    logic [W-1:0]  shadow;
    logic [5:0]    cnt;
    logic [RW-1:0] res_idx;
    logic [MW-1:0] mark_idx;
    logic          done_q;

    logic [8:0]    marks [NUMRESULTS][NUMPOSITIONS+1];
    logic [8:0]    cur_mark;
    logic [8:0]    nxt_mark_val;
    logic [RW-1:0] nxt_res;
    logic [MW-1:0] nxt_mark;
    logic          accept;
    logic          trigger;
    logic          last_mark;
    logic          last_res;
    logic          end_now;

    assign fsm_state = state;

    // Unpack the shadow copy: result 0 and mark 0 sit at the top of the vector.
    for (genvar k = 0; k < NUMRESULTS; k++) begin : g_res
        for (genvar j = 0; j <= NUMPOSITIONS; j++) begin : g_mark
            assign marks[k][j] = shadow[W-1-(k*(NUMPOSITIONS+1)+j)*9 -: 9];
        end
    end

    // Walk bookkeeping: which mark is current, which comes next, and when the body ends.
    always_comb begin
        accept       = tx_valid && tx_ready;
        trigger      = done && !done_q;
        last_mark    = (mark_idx == LAST_MARK);
        last_res     = ((6'(res_idx) + 6'd1) == cnt);
        nxt_res      = last_mark ? (res_idx + RW'(1)) : res_idx;
        nxt_mark     = last_mark ? '0 : (mark_idx + MW'(1));
        cur_mark     = marks[res_idx][mark_idx];
        nxt_mark_val = marks[nxt_res][nxt_mark];
        end_now      = accept && (((state == COUNT) && (cnt == 6'd0)) ||
                                  ((state == MARK_LO) && last_mark && last_res));
    end

`ifdef GOLOMB_STREAM_CHECKSUM_EN
    logic [7:0] chk;

    // Running XOR of every accepted byte; restarts when a new frame is captured.
    always_ff @(posedge clock or posedge RESET) begin
        if (RESET) begin
            chk <= 8'h00;
        end else if ((state == IDLE) && trigger) begin
            chk <= 8'h00;
        end else if (accept && (state != CHK)) begin
            chk <= chk ^ tx_data;
        end
    end
`endif

    // Frame sequencer: capture on trigger, then present one byte per accepted transfer.
    always_ff @(posedge clock or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= 6'd0;
            res_idx    <= '0;
            mark_idx   <= '0;
            done_q     <= 1'b1;
            shadow     <= '0;
        end else begin
            done_q <= done;
            if (end_now) begin
`ifdef GOLOMB_STREAM_CHECKSUM_EN
                state   <= CHK;
                tx_data <= chk ^ tx_data;
`else
                state      <= FIN;
                tx_valid   <= 1'b0;
                frame_done <= 1'b1;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (trigger) begin
                            shadow   <= results;
                            cnt      <= (numResults > 6'(NUMRESULTS)) ? 6'(NUMRESULTS) : numResults;
                            res_idx  <= '0;
                            mark_idx <= '0;
                            tx_data  <= 8'hA5;
                            tx_valid <= 1'b1;
                            busy     <= 1'b1;
                            state    <= HEADER;
                        end
                    end
                    HEADER: begin
                        if (accept) begin
                            tx_data <= {2'b00, cnt};
                            state   <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (accept) begin
                            tx_data <= {7'b0, marks[0][0][8]};
                            state   <= MARK_HI;
                        end
                    end
                    MARK_HI: begin
                        if (accept) begin
                            tx_data <= cur_mark[7:0];
                            state   <= MARK_LO;
                        end
                    end
                    MARK_LO: begin
                        if (accept) begin
                            res_idx  <= nxt_res;
                            mark_idx <= nxt_mark;
                            tx_data  <= {7'b0, nxt_mark_val[8]};
                            state    <= MARK_HI;
                        end
                    end
`ifdef GOLOMB_STREAM_CHECKSUM_EN
                    CHK: begin
                        if (accept) begin
                            tx_valid   <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= FIN;
                        end
                    end
`endif
                    FIN: begin
                        frame_done <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_golomb_result_streamer.sv
// tb_golomb_result_streamer: directed frames against a byte-list model of the
// stream, with a per-cycle monitor on the handshake and frame_done timing.
module tb_golomb_result_streamer;

  localparam int NP = 5;
  localparam int NR = 10;
  localparam int W  = (NP + 1) * 9 * NR;

  logic         clock = 1'b0;
  logic         RESET = 1'b1;
  logic         done = 1'b0;
  logic [5:0]   numResults = 6'd0;
  logic [W-1:0] results = '0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic         busy;
  logic         frame_done;
  logic [2:0]   fsm_state;

  logic [8:0]   rulers [NR][NP+1];
  logic [7:0]   exp_q[$];
  logic [7:0]   got_q[$];
  logic [7:0]   lit_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  bit           bp_on = 0;
  int           bp_ph = 0;
  bit           last_acc = 0;
  bit           stall_prev = 0;
  logic [7:0]   stall_data = 8'h00;
  bit           bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  golomb_result_streamer #(.NUMPOSITIONS(NP), .NUMRESULTS(NR)) dut (
    .clock(clock),
    .RESET(RESET),
    .done(done),
    .numResults(numResults),
    .results(results),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .frame_done(frame_done),
    .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // ready pattern driver for the backpressure case
  always @(posedge clock) begin
    #1;
    if (bp_on) begin
      tx_ready = bp_pat[bp_ph];
      bp_ph = (bp_ph + 1) % 4;
    end
  end

  // scoreboard / monitor: every accepted byte is checked against the model queue
  always @(negedge clock) begin
    if (RESET) begin
      last_acc = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, stall_data);
      end
      check("frame_done_timing", frame_done, last_acc);
      last_acc = 0;
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_byte: got %0h required none", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data === e) n_pass++;
          else $display("FAIL stream_byte: got %0h required %0h", tx_data, e);
          if (exp_q.size() == 0) last_acc = 1;
        end
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  // model: byte list straight from the framing rules and the ruler table
  task automatic build_expected(input int nres);
    int c;
    logic [7:0] x;
    c = (nres > NR) ? NR : nres;
    x = 8'hA5;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(c));
    x ^= 8'(c);
    for (int k = 0; k < c; k++) begin
      for (int j = 0; j <= NP; j++) begin
        exp_q.push_back({7'b0, rulers[k][j][8]});
        exp_q.push_back(rulers[k][j][7:0]);
        x ^= {7'b0, rulers[k][j][8]};
        x ^= rulers[k][j][7:0];
      end
    end
`ifdef GOLOMB_STREAM_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic pack_rulers();
    for (int k = 0; k < NR; k++)
      for (int j = 0; j <= NP; j++)
        results[W-1-(k*(NP+1)+j)*9 -: 9] = rulers[k][j];
  endtask

  // driver: load inputs, set expectations, make a done 0->1 edge, check first byte
  task automatic start_frame(input int nres);
    pack_rulers();
    numResults = 6'(nres);
    got_q.delete();
    build_expected(nres);
    done = 1'b0;
    @(posedge clock); #1;
    done = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("first_valid", tx_valid, 1);
    check("first_busy", busy, 1);
    check("first_byte", tx_data, 8'hA5);
  endtask

  task automatic wait_frame(input string name, output int cycles);
    bit seen;
    seen = 0;
    cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      cycles = i + 1;
      if (frame_done) begin
        seen = 1;
        break;
      end
    end
    check({name, "_frame_seen"}, seen, 1);
    if (seen) begin
      check({name, "_valid_low_at_done"}, tx_valid, 0);
      check({name, "_busy_at_done"}, busy, 1);
      @(negedge clock);
      check({name, "_busy_clear"}, busy, 0);
      check({name, "_all_bytes"}, exp_q.size(), 0);
    end
  endtask

  task automatic compare_literal(input string name);
    check({name, "_len"}, got_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size() && i < got_q.size(); i++)
      check({name, "_lit_byte"}, got_q[i], lit_q[i]);
  endtask

  task automatic set_single_lit();
    lit_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h04,
              8'h00, 8'h0A, 8'h00, 8'h0C, 8'h00, 8'h11, 8'hB6};
`ifndef GOLOMB_STREAM_CHECKSUM_EN
    void'(lit_q.pop_back());
`endif
  endtask

  task automatic wait_bytes(input int n, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (got_q.size() >= n) begin
        ok = 1;
        break;
      end
      @(negedge clock);
    end
    check({name, "_progress"}, ok, 1);
  endtask

  task automatic quiet_window(input string name);
    int active;
    active = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (tx_valid || busy) active++;
    end
    check(name, active, 0);
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < NR; k++)
      for (int j = 0; j <= NP; j++)
        rulers[k][j] = 9'((k * 37 + j * 53 + 5) % 512);
    rulers[0][0] = 9'd0;  rulers[0][1] = 9'd1;  rulers[0][2] = 9'd4;
    rulers[0][3] = 9'd10; rulers[0][4] = 9'd12; rulers[0][5] = 9'd17;

    // reset values
    repeat (2) @(negedge clock);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    RESET = 1'b0;
    repeat (2) @(negedge clock);

    // model pinned to the hand-computed single-result frame
    set_single_lit();
    build_expected(1);
    check("model_single_len", exp_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size() && i < exp_q.size(); i++)
      check("model_single_byte", exp_q[i], lit_q[i]);
    exp_q.delete();

    // single result at full rate; inputs scrambled after capture
    start_frame(1);
    results = ~results;
    numResults = 6'd7;
    wait_frame("single", cyc);
    check("single_cycles", cyc, lit_q.size());
    compare_literal("single");

    // empty result set
    start_frame(0);
    wait_frame("empty", cyc);
`ifdef GOLOMB_STREAM_CHECKSUM_EN
    lit_q = '{8'hA5, 8'h00, 8'hA5};
`else
    lit_q = '{8'hA5, 8'h00};
`endif
    check("empty_cycles", cyc, lit_q.size());
    compare_literal("empty");

    // clamp: 12 requested, 10 sent
    start_frame(12);
    wait_frame("clamp", cyc);
`ifdef GOLOMB_STREAM_CHECKSUM_EN
    check("clamp_len", got_q.size(), 123);
    check("clamp_cycles", cyc, 123);
`else
    check("clamp_len", got_q.size(), 122);
    check("clamp_cycles", cyc, 122);
`endif
    if (got_q.size() > 1) check("clamp_count_byte", got_q[1], 8'h0A);

    // backpressure
    bp_ph = 0;
    bp_on = 1;
    start_frame(1);
    wait_frame("bp", cyc);
    bp_on = 0;
    @(posedge clock); #1;
    tx_ready = 1'b1;
    set_single_lit();
    compare_literal("bp");

    // retrigger mid-frame is ignored
    start_frame(1);
    wait_bytes(4, "retrig");
    done = 1'b0;
    @(posedge clock); #1;
    done = 1'b1;
    wait_frame("retrig", cyc);
    compare_literal("retrig");
    quiet_window("retrig_no_second_frame");

    // done held high through reset release
    @(negedge clock);
    RESET = 1'b1;
    repeat (3) @(negedge clock);
    RESET = 1'b0;
    quiet_window("done_high_at_reset_no_frame");

    // reset mid-frame after the 5th byte
    start_frame(1);
    wait_bytes(5, "midrst");
    @(posedge clock);
    #2;
    RESET = 1'b1;
    #1;
    check("midrst_tx_data", tx_data, 8'h00);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_done", frame_done, 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    RESET = 1'b0;
    @(negedge clock);
    start_frame(1);
    wait_frame("after_rst", cyc);
    compare_literal("after_rst");

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
